// File: rtl/r4u3_one_rd_ctrl_pkg.sv
// rtl/r4u3_one_rd_ctrl_pkg.sv - shared widths, FSM encoding and tag width for the stage-one read sequencer
`ifndef MAN_WIDTH
`define MAN_WIDTH 12
`endif
`ifndef EXP_WIDTH
`define EXP_WIDTH 6
`endif

package r4u3_one_rd_ctrl_pkg;
    localparam int PKG_AW = 8;
    localparam int PKG_DW = `MAN_WIDTH + `MAN_WIDTH + `EXP_WIDTH;
    localparam int LEG_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/r4u3_skid2.sv
// rtl/r4u3_skid2.sv - two-entry FIFO holding RAM words with their {leg, last} tags
module r4u3_skid2
    import r4u3_one_rd_ctrl_pkg::*;
#(
    parameter int DW = PKG_DW
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [DW-1:0]    i_data,
    input  logic [LEG_W-1:0] i_leg,
    input  logic             i_last,
    input  logic             i_pop,
    output logic [DW-1:0]    o_data,
    output logic [LEG_W-1:0] o_leg,
    output logic             o_last,
    output logic [1:0]       o_count
);
    localparam int EW = DW + LEG_W + 1;

    logic [EW-1:0] r_ent0;
    logic [EW-1:0] r_ent1;
    logic [1:0]    r_count;
    logic [EW-1:0] w_in;

    assign w_in = {i_data, i_leg, i_last};

    // Entry 0 is always the head, so the output only moves on a pop.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_ent0 <= w_in;
                    else                 r_ent1 <= w_in;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_ent0 <= w_in;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= w_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {o_data, o_leg, o_last} = r_ent0;
    assign o_count = r_count;
endmodule

// File: rtl/r4u3_one_rd_ctrl.sv
// rtl/r4u3_one_rd_ctrl.sv - stage-one butterfly read sequencer: x[k+m*Q] reads streamed through a skid buffer
module r4u3_one_rd_ctrl
    import r4u3_one_rd_ctrl_pkg::*;
#(
    parameter int AW = PKG_AW,
    parameter int DW = PKG_DW
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             frm_start,
    input  logic [AW-2:0]    q_len,
    output logic             busy,
    output logic             frm_done,
    output logic [AW-1:0]    rd_addr,
    output logic             rd_en,
    input  logic [DW-1:0]    rd_data,
    output logic [DW-1:0]    dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic [LEG_W-1:0] dout_leg,
    output logic             dout_last
);
    localparam int QW = AW - 1;
    localparam logic [QW-1:0] QMAX = QW'(2 ** (AW - 2));

    state_t           r_state;
    state_t           w_state_nxt;
    logic [QW-1:0]    r_q;
    logic [QW-1:0]    r_k;
    logic [LEG_W-1:0] r_m;
    logic             r_if_vld;
    logic [LEG_W-1:0] r_if_leg;
    logic             r_if_last;

    logic [QW-1:0]    w_q_in;
    logic [1:0]       w_count;
    logic [2:0]       w_outst;
    logic             w_room;
    logic             w_pop;
    logic             w_issue;
    logic             w_last_issue;
    logic [AW-1:0]    w_addr;

    assign w_q_in       = (q_len > QMAX) ? QMAX : q_len;
    assign w_pop        = dout_vld & dout_rdy;
    assign w_last_issue = (r_k == r_q - 1'b1) && (r_m == 2'd3);
    assign w_addr       = AW'(r_k) + AW'(r_m) * AW'(r_q);

    // A word popped this cycle frees its slot for a read issued this cycle.
    assign w_outst = 3'(w_count) + 3'(r_if_vld) - 3'(w_pop);
    assign w_room  = (w_outst < 3'd2);

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frm_start) w_state_nxt = (w_q_in == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                w_issue = w_room;
                if (w_room && w_last_issue) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && dout_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_k       <= '0;
            r_m       <= '0;
            r_if_vld  <= 1'b0;
            r_if_leg  <= '0;
            r_if_last <= 1'b0;
        end else begin
            r_if_vld  <= w_issue;
            r_if_leg  <= r_m;
            r_if_last <= w_last_issue;
            if (r_state == ST_IDLE && frm_start) begin
                r_q <= w_q_in;
                r_k <= '0;
                r_m <= '0;
            end else if (w_issue) begin
                r_m <= r_m + 2'd1;
                if (r_m == 2'd3) r_k <= r_k + 1'b1;
            end
        end
    end

    r4u3_skid2 #(.DW(DW)) u_skid (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .i_push  (r_if_vld),
        .i_data  (rd_data),
        .i_leg   (r_if_leg),
        .i_last  (r_if_last),
        .i_pop   (w_pop),
        .o_data  (dout),
        .o_leg   (dout_leg),
        .o_last  (dout_last),
        .o_count (w_count)
    );

    assign dout_vld = (w_count != 2'd0);
    assign rd_en    = w_issue;
    assign rd_addr  = w_issue ? w_addr : '0;
    assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign frm_done = (r_state == ST_DONE);
endmodule

// File: doc/r4u3_one_rd_ctrl.md
Name: r4u3_one_rd_ctrl

Overview:
- Read-side sequencer for the radix-4 unit 3 stage-one RAM (256 words, registered read, 1-cycle latency).
- After the writer has filled a frame of N = 4*q_len samples, this block generates stage-one butterfly read addresses: x[k], x[k+Q], x[k+2Q], x[k+3Q] for k = 0..Q-1.
- It streams the read words to the radix-4 butterfly with a valid/ready handshake, and absorbs RAM read latency under backpressure with a 2-entry skid buffer.

Parameters:
- AW, 8, RAM address width; max N = 2^AW = 256.
- DW, `MAN_WIDTH+`MAN_WIDTH+`EXP_WIDTH, word width (re mantissa, im mantissa, block exponent).

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frm_start  in  1  one-cycle pulse: RAM frame complete, begin reading.
- q_len  in  AW-1  quarter length Q, sampled on accepted frm_start; values >64 clamp to 64.
- busy  out  1  frame read in progress.
- frm_done  out  1  one-cycle pulse when the last word is accepted downstream.
- rd_addr  out  AW  RAM read address.
- rd_en  out  1  read issued this cycle (bench/monitor only; RAM reads every cycle).
- rd_data  in  DW  RAM registered read data, valid 1 cycle after rd_addr/rd_en.
- dout  out  DW  word to butterfly.
- dout_vld  out  1  dout valid.
- dout_rdy  in  1  downstream ready; a transfer occurs when vld & rdy.
- dout_leg  out  2  butterfly leg m (0..3) of dout.
- dout_last  out  1  last word of frame.

Behaviour:
- Reset (async, rst_n=0): busy=0, frm_done=0, rd_addr=0, rd_en=0, dout_vld=0, dout=0, dout_leg=0, dout_last=0. Counters cleared, skid buffer empty. Reset mid-frame aborts the frame with no frm_done.
- FSM states:
  - IDLE: on frm_start, latch Q. Q=0 → DONE. Otherwise → RUN and set busy=1 next cycle.
  - RUN: issue reads.
  - DRAIN: all reads issued, waiting for the buffer to empty.
  - DONE: one cycle; frm_done=1, busy=0 → IDLE.
- frm_start is ignored unless in IDLE.
- Address order: k outer (0..Q-1), m inner (0..3). rd_addr = k + m*Q, computed in AW bits; no wrap occurs because 4Q <= 256.
- Issue rule: in RUN, rd_en=1 when (skid occupancy + reads in flight) < 2, evaluated with the current-cycle pop (vld & rdy) counted as freeing a slot. This gives full throughput of 1 word/cycle with dout_rdy held high.
- Data path: rd_data is captured into the skid FIFO one cycle after rd_en, together with its tag {m, last}. dout, dout_leg and dout_last are taken from the FIFO head. dout_vld = FIFO non-empty.
- Latency: frm_start → first rd_en is 1 cycle; first rd_en → dout_vld is 2 cycles (RAM register + skid register).
- After the final issue (k=Q-1, m=3), RUN → DRAIN. DRAIN → DONE on the cycle the last-tagged word transfers.
- The FIFO never overflows. A simultaneous push and pop when full is not possible by the issue rule; when not full it is allowed.
- dout and its tags hold stable while dout_vld & !dout_rdy.

Decomposition:
- Shared package/header: DW macro expression, AW, the FSM state encodings, and the leg tag width.
- One natural sub-module, r4u3_skid2: a 2-entry FIFO of {DW data, 2-bit leg, last} with push, pop, count outputs.

Test Plan:
- RAM preloaded with addr-valued words; Q=4, frm_start, dout_rdy=1 → dout sequence 0,4,8,12,1,5,9,13,...,3,7,11,15. Legs cycle 0..3. dout_last on the 16th word. frm_done 1 cycle after it. 16 consecutive transfer cycles.
- Q=64 full frame, random 30% dout_rdy low → 256 words in order, no drop or duplicate; rd_addr last = 255; the (occupancy + in-flight) <= 2 invariant holds every cycle.
- dout_rdy held low for 10 cycles after the first read → exactly 2 reads issued, dout stable; on release, the stream resumes with no gap.
- Q=0 start → no rd_en, frm_done pulse exactly once; q_len=100 → behaves as Q=64 (256 words).
- frm_start pulsed during busy → ignored, frame length unchanged; rst_n asserted mid-frame → all outputs 0 immediately; the next frame starts cleanly from address 0.
